// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding selects, load-use / RAW stalls,
// jump redirect flush FSM and a mul/div hold counter.
module hazard_ctrl #(
  parameter int REG_IDX_W = 5,
  parameter int MD_LAT    = 4,
  parameter bit FWD_EN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs1_idx_id,
  input  logic [REG_IDX_W-1:0] rs2_idx_id,
  input  logic                 rs1_used_id,
  input  logic                 rs2_used_id,
  input  logic [REG_IDX_W-1:0] rs1_idx_ex,
  input  logic [REG_IDX_W-1:0] rs2_idx_ex,
  input  logic [REG_IDX_W-1:0] rd_idx_ex,
  input  logic                 reg_wen_ex,
  input  logic                 is_load_ex,
  input  logic                 md_op_ex,
  input  logic                 jump_en_ex,
  input  logic [REG_IDX_W-1:0] rd_idx_mem,
  input  logic [REG_IDX_W-1:0] rd_idx_wb,
  input  logic                 reg_wen_mem,
  input  logic                 reg_wen_wb,
  input  logic                 imem_rvalid,
  output logic                 stall_en_if,
  output logic                 stall_en_if2id,
  output logic                 stall_en_id2ex,
  output logic                 flush_en_if2id,
  output logic                 flush_en_id2ex,
  output logic                 flush_en_ex2mem,
  output logic [1:0]           alu_rs1_data_sel_ex,
  output logic [1:0]           alu_rs2_data_sel_ex,
  output logic                 load_stall,
  output logic                 md_busy,
  output logic                 redirect_wait
);

  localparam int CNT_W = $clog2(MD_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [REG_IDX_W-1:0] IDX_ZERO = '0;

  localparam logic [1:0] SEL_BUF = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic redirect_flush;
  logic md_hold;
  logic raw_hit;
  logic ls_int;

  function automatic logic hit(input logic used,
                               input logic [REG_IDX_W-1:0] src,
                               input logic [REG_IDX_W-1:0] rd,
                               input logic wen);
    return used && (src == rd) && wen && (rd != IDX_ZERO);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_IDX_W-1:0] src);
    if (src == IDX_ZERO)
      return SEL_BUF;
    else if (reg_wen_mem && (src == rd_idx_mem))
      return SEL_MEM;
    else if (reg_wen_wb && (src == rd_idx_wb))
      return SEL_WB;
    else
      return SEL_BUF;
  endfunction

  always_comb begin
    redirect_flush = 1'b0;
    state_nxt      = state;
    case (state)
      ST_IDLE: begin
        redirect_flush = jump_en_ex;
        if (jump_en_ex)
          state_nxt = ST_WAIT;
      end
      default: begin
        // EX holds a bubble while waiting, so a jump here is not possible.
        redirect_flush = !imem_rvalid;
        if (imem_rvalid)
          state_nxt = ST_IDLE;
      end
    endcase
  end

  // A taken jump kills the mul/div in EX, so it never holds.
  always_comb begin
    md_hold = md_op_ex && !jump_en_ex && (cnt < CNT_LAST);
    cnt_nxt = md_hold ? (cnt + CNT_ONE) : '0;
  end

  always_comb begin
    raw_hit = 1'b0;
    if (FWD_EN) begin
      raw_hit = is_load_ex &&
                (hit(rs1_used_id, rs1_idx_id, rd_idx_ex, reg_wen_ex) ||
                 hit(rs2_used_id, rs2_idx_id, rd_idx_ex, reg_wen_ex));
    end else begin
      raw_hit = hit(rs1_used_id, rs1_idx_id, rd_idx_ex,  reg_wen_ex)  ||
                hit(rs2_used_id, rs2_idx_id, rd_idx_ex,  reg_wen_ex)  ||
                hit(rs1_used_id, rs1_idx_id, rd_idx_mem, reg_wen_mem) ||
                hit(rs2_used_id, rs2_idx_id, rd_idx_mem, reg_wen_mem) ||
                hit(rs1_used_id, rs1_idx_id, rd_idx_wb,  reg_wen_wb)  ||
                hit(rs2_used_id, rs2_idx_id, rd_idx_wb,  reg_wen_wb);
    end
    ls_int = raw_hit && !md_hold && !redirect_flush;
  end

  always_comb begin
    stall_en_if         = 1'b0;
    stall_en_if2id      = 1'b0;
    stall_en_id2ex      = 1'b0;
    flush_en_if2id      = 1'b0;
    flush_en_id2ex      = 1'b0;
    flush_en_ex2mem     = 1'b0;
    alu_rs1_data_sel_ex = SEL_BUF;
    alu_rs2_data_sel_ex = SEL_BUF;
    load_stall          = 1'b0;
    md_busy             = 1'b0;
    redirect_wait       = 1'b0;
    if (!rst) begin
      // Redirect flush wins over any front-end stall.
      stall_en_if     = (ls_int || md_hold) && !redirect_flush;
      stall_en_if2id  = (ls_int || md_hold) && !redirect_flush;
      stall_en_id2ex  = md_hold;
      flush_en_if2id  = redirect_flush;
      flush_en_id2ex  = ls_int || redirect_flush;
      flush_en_ex2mem = md_hold;
      load_stall      = ls_int;
      md_busy         = md_hold;
      redirect_wait   = (state == ST_WAIT);
      if (FWD_EN) begin
        alu_rs1_data_sel_ex = fwd_sel(rs1_idx_ex);
        alu_rs2_data_sel_ex = fwd_sel(rs2_idx_ex);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three configurations (default, MD_LAT=1, FWD_EN=0)
// driven in parallel, checked by directed scenarios and a random reference model.
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  logic [4:0] rs1_idx_id, rs2_idx_id, rs1_idx_ex, rs2_idx_ex, rd_idx_ex;
  logic [4:0] rd_idx_mem, rd_idx_wb;
  logic rs1_used_id, rs2_used_id, reg_wen_ex, is_load_ex, md_op_ex, jump_en_ex;
  logic reg_wen_mem, reg_wen_wb, imem_rvalid;

  // {stall_if, stall_if2id, stall_id2ex, flush_if2id, flush_id2ex, flush_ex2mem,
  //  sel1[1:0], sel2[1:0], load_stall, md_busy, redirect_wait}
  wire [12:0] o_a, o_b, o_c;

  localparam int B_SIF = 12, B_SI2 = 11, B_SI3 = 10, B_FI2 = 9, B_FI3 = 8, B_FEM = 7;
  localparam int B_LS = 2, B_MB = 1, B_RW = 0;

  int checks = 0;
  int errors = 0;

  int  lat_p [3] = '{4, 1, 4};
  bit  fwd_p [3] = '{1'b1, 1'b1, 1'b0};
  bit  wait_m [3];
  int  streak_m [3];

  hazard_ctrl #(.REG_IDX_W(5), .MD_LAT(4), .FWD_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .rs1_idx_id(rs1_idx_id), .rs2_idx_id(rs2_idx_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rs1_idx_ex(rs1_idx_ex), .rs2_idx_ex(rs2_idx_ex), .rd_idx_ex(rd_idx_ex),
    .reg_wen_ex(reg_wen_ex), .is_load_ex(is_load_ex), .md_op_ex(md_op_ex), .jump_en_ex(jump_en_ex),
    .rd_idx_mem(rd_idx_mem), .rd_idx_wb(rd_idx_wb), .reg_wen_mem(reg_wen_mem), .reg_wen_wb(reg_wen_wb),
    .imem_rvalid(imem_rvalid),
    .stall_en_if(o_a[12]), .stall_en_if2id(o_a[11]), .stall_en_id2ex(o_a[10]),
    .flush_en_if2id(o_a[9]), .flush_en_id2ex(o_a[8]), .flush_en_ex2mem(o_a[7]),
    .alu_rs1_data_sel_ex(o_a[6:5]), .alu_rs2_data_sel_ex(o_a[4:3]),
    .load_stall(o_a[2]), .md_busy(o_a[1]), .redirect_wait(o_a[0]));

  hazard_ctrl #(.REG_IDX_W(5), .MD_LAT(1), .FWD_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst),
    .rs1_idx_id(rs1_idx_id), .rs2_idx_id(rs2_idx_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rs1_idx_ex(rs1_idx_ex), .rs2_idx_ex(rs2_idx_ex), .rd_idx_ex(rd_idx_ex),
    .reg_wen_ex(reg_wen_ex), .is_load_ex(is_load_ex), .md_op_ex(md_op_ex), .jump_en_ex(jump_en_ex),
    .rd_idx_mem(rd_idx_mem), .rd_idx_wb(rd_idx_wb), .reg_wen_mem(reg_wen_mem), .reg_wen_wb(reg_wen_wb),
    .imem_rvalid(imem_rvalid),
    .stall_en_if(o_b[12]), .stall_en_if2id(o_b[11]), .stall_en_id2ex(o_b[10]),
    .flush_en_if2id(o_b[9]), .flush_en_id2ex(o_b[8]), .flush_en_ex2mem(o_b[7]),
    .alu_rs1_data_sel_ex(o_b[6:5]), .alu_rs2_data_sel_ex(o_b[4:3]),
    .load_stall(o_b[2]), .md_busy(o_b[1]), .redirect_wait(o_b[0]));

  hazard_ctrl #(.REG_IDX_W(5), .MD_LAT(4), .FWD_EN(1'b0)) dut_c (
    .clk(clk), .rst(rst),
    .rs1_idx_id(rs1_idx_id), .rs2_idx_id(rs2_idx_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rs1_idx_ex(rs1_idx_ex), .rs2_idx_ex(rs2_idx_ex), .rd_idx_ex(rd_idx_ex),
    .reg_wen_ex(reg_wen_ex), .is_load_ex(is_load_ex), .md_op_ex(md_op_ex), .jump_en_ex(jump_en_ex),
    .rd_idx_mem(rd_idx_mem), .rd_idx_wb(rd_idx_wb), .reg_wen_mem(reg_wen_mem), .reg_wen_wb(reg_wen_wb),
    .imem_rvalid(imem_rvalid),
    .stall_en_if(o_c[12]), .stall_en_if2id(o_c[11]), .stall_en_id2ex(o_c[10]),
    .flush_en_if2id(o_c[9]), .flush_en_id2ex(o_c[8]), .flush_en_ex2mem(o_c[7]),
    .alu_rs1_data_sel_ex(o_c[6:5]), .alu_rs2_data_sel_ex(o_c[4:3]),
    .load_stall(o_c[2]), .md_busy(o_c[1]), .redirect_wait(o_c[0]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] pick(input int k);
    if (k == 0) return o_a;
    else if (k == 1) return o_b;
    else return o_c;
  endfunction

  function automatic bit hit(input bit used, input logic [4:0] s, input logic [4:0] rd, input bit wen);
    return used && (s == rd) && wen && (rd != 5'd0);
  endfunction

  function automatic logic [1:0] ref_sel(input bit fwd, input logic [4:0] s);
    if (!fwd || s == 5'd0) return 2'd0;
    if (reg_wen_mem && s == rd_idx_mem) return 2'd1;
    if (reg_wen_wb && s == rd_idx_wb) return 2'd2;
    return 2'd0;
  endfunction

  // Expected outputs for configuration k from the current inputs and model state.
  function automatic logic [12:0] ref_out(input int k);
    bit jf, busy, raw, ls, st;
    if (rst) return 13'd0;
    jf   = wait_m[k] ? !imem_rvalid : jump_en_ex;
    busy = md_op_ex && !jump_en_ex && ((streak_m[k] % lat_p[k]) != lat_p[k] - 1);
    if (fwd_p[k])
      raw = is_load_ex && (hit(rs1_used_id, rs1_idx_id, rd_idx_ex, reg_wen_ex) ||
                           hit(rs2_used_id, rs2_idx_id, rd_idx_ex, reg_wen_ex));
    else
      raw = hit(rs1_used_id, rs1_idx_id, rd_idx_ex, reg_wen_ex) ||
            hit(rs2_used_id, rs2_idx_id, rd_idx_ex, reg_wen_ex) ||
            hit(rs1_used_id, rs1_idx_id, rd_idx_mem, reg_wen_mem) ||
            hit(rs2_used_id, rs2_idx_id, rd_idx_mem, reg_wen_mem) ||
            hit(rs1_used_id, rs1_idx_id, rd_idx_wb, reg_wen_wb) ||
            hit(rs2_used_id, rs2_idx_id, rd_idx_wb, reg_wen_wb);
    ls = raw && !busy && !jf;
    st = (ls || busy) && !jf;
    return {st, st, busy, jf, ls || jf, busy,
            ref_sel(fwd_p[k], rs1_idx_ex), ref_sel(fwd_p[k], rs2_idx_ex),
            ls, busy, wait_m[k]};
  endfunction

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        wait_m[k] = 1'b0;
        streak_m[k] = 0;
      end else begin
        wait_m[k] = wait_m[k] ? !imem_rvalid : jump_en_ex;
        streak_m[k] = (jump_en_ex || !md_op_ex) ? 0 : streak_m[k] + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rs1_idx_id = 0; rs2_idx_id = 0; rs1_used_id = 0; rs2_used_id = 0;
    rs1_idx_ex = 0; rs2_idx_ex = 0; rd_idx_ex = 0;
    reg_wen_ex = 0; is_load_ex = 0; md_op_ex = 0; jump_en_ex = 0;
    rd_idx_mem = 0; rd_idx_wb = 0; reg_wen_mem = 0; reg_wen_wb = 0; imem_rvalid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    rs1_idx_id = 5'd3; rs2_idx_id = 5'd3; rs1_used_id = 1; rs2_used_id = 1;
    rs1_idx_ex = 5'd3; rs2_idx_ex = 5'd3; rd_idx_ex = 5'd3; rd_idx_mem = 5'd3; rd_idx_wb = 5'd3;
    reg_wen_ex = 1; is_load_ex = 1; md_op_ex = 1; jump_en_ex = 1;
    reg_wen_mem = 1; reg_wen_wb = 1; imem_rvalid = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (pick(k) !== 13'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %b want %b", k, pick(k), 13'd0);
      end
    end
    advance();
    rst = 0;
    clear_inputs();
    #1;
    checks++;
    if (o_a !== 13'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got %b want %b", o_a, 13'd0);
    end
    advance();
  endtask

  task automatic test_forward();
    rs1_idx_ex = 5'd5; rd_idx_mem = 5'd5; rd_idx_wb = 5'd5; reg_wen_mem = 1; reg_wen_wb = 1;
    #1;
    checks++;
    if (o_a[6:5] !== 2'd1) begin errors++; $display("FAIL fwd_mem_priority: got %0d want 1", o_a[6:5]); end
    checks++;
    if (o_c[6:5] !== 2'd0) begin errors++; $display("FAIL fwd_disabled_sel: got %0d want 0", o_c[6:5]); end
    advance();
    reg_wen_mem = 0;
    #1;
    checks++;
    if (o_a[6:5] !== 2'd2) begin errors++; $display("FAIL fwd_wb: got %0d want 2", o_a[6:5]); end
    advance();
    rs2_idx_ex = 5'd5; reg_wen_mem = 1; rd_idx_mem = 5'd4;
    #1;
    checks++;
    if (o_a[4:3] !== 2'd2) begin errors++; $display("FAIL fwd_rs2_wb: got %0d want 2", o_a[4:3]); end
    advance();
    rs1_idx_ex = 5'd0; rd_idx_mem = 5'd0; rd_idx_wb = 5'd0;
    #1;
    checks++;
    if (o_a[6:5] !== 2'd0) begin errors++; $display("FAIL fwd_idx0: got %0d want 0", o_a[6:5]); end
    advance();
    clear_inputs();
  endtask

  task automatic test_load_use();
    is_load_ex = 1; rd_idx_ex = 5'd7; reg_wen_ex = 1; rs2_idx_id = 5'd7; rs2_used_id = 1;
    #1;
    checks++;
    if ({o_a[B_LS], o_a[B_SIF], o_a[B_SI2], o_a[B_FI3]} !== 4'b1111) begin
      errors++;
      $display("FAIL load_use_stall: got %b want 1111", {o_a[B_LS], o_a[B_SIF], o_a[B_SI2], o_a[B_FI3]});
    end
    advance();
    rs2_used_id = 0;
    #1;
    checks++;
    if ({o_a[B_LS], o_a[B_SIF], o_a[B_SI2], o_a[B_FI3]} !== 4'b0000) begin
      errors++;
      $display("FAIL load_use_unused: got %b want 0000", {o_a[B_LS], o_a[B_SIF], o_a[B_SI2], o_a[B_FI3]});
    end
    advance();
    rs2_used_id = 1; rd_idx_ex = 5'd0; rs2_idx_id = 5'd0;
    #1;
    checks++;
    if (o_a[B_LS] !== 1'b0) begin errors++; $display("FAIL load_use_idx0: got %b want 0", o_a[B_LS]); end
    advance();
    clear_inputs();
  endtask

  task automatic test_muldiv();
    int eb [4] = '{1, 1, 1, 0};
    md_op_ex = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({o_a[B_MB], o_a[B_SI3], o_a[B_FEM]} !== {3{eb[i][0]}}) begin
        errors++;
        $display("FAIL muldiv_busy cyc%0d: got %b want %b", i, {o_a[B_MB], o_a[B_SI3], o_a[B_FEM]}, {3{eb[i][0]}});
      end
      checks++;
      if (o_b[B_MB] !== 1'b0) begin errors++; $display("FAIL muldiv_lat1 cyc%0d: got %b want 0", i, o_b[B_MB]); end
      advance();
    end
    // Back-to-back mul/div: the next instruction starts a fresh hold.
    #1;
    checks++;
    if (o_a[B_MB] !== 1'b1) begin errors++; $display("FAIL muldiv_b2b: got %b want 1", o_a[B_MB]); end
    jump_en_ex = 1;
    #1;
    checks++;
    if (o_a[B_MB] !== 1'b0) begin errors++; $display("FAIL muldiv_jump_wins: got %b want 0", o_a[B_MB]); end
    advance();
    jump_en_ex = 0; md_op_ex = 0; imem_rvalid = 1;
    advance();
    clear_inputs();
  endtask

  task automatic test_redirect();
    bit ef [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit ew [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      jump_en_ex = (i == 0);
      imem_rvalid = (i == 3);
      rs1_used_id = 1; rs1_idx_id = 5'd2; rd_idx_ex = 5'd2; reg_wen_ex = 1; is_load_ex = (i < 3);
      #1;
      checks++;
      if ({o_a[B_FI2], o_a[B_RW]} !== {ef[i], ew[i]}) begin
        errors++;
        $display("FAIL redirect cyc%0d: got flush=%b wait=%b want flush=%b wait=%b", i, o_a[B_FI2], o_a[B_RW], ef[i], ew[i]);
      end
      if (ef[i]) begin
        checks++;
        if ({o_a[B_SIF], o_a[B_SI2], o_a[B_LS], o_a[B_FI3]} !== 4'b0001) begin
          errors++;
          $display("FAIL redirect_override cyc%0d: got %b want 0001", i, {o_a[B_SIF], o_a[B_SI2], o_a[B_LS], o_a[B_FI3]});
        end
      end
      advance();
    end
    clear_inputs();
    jump_en_ex = 1;
    advance();
    jump_en_ex = 0; imem_rvalid = 1;
    #1;
    checks++;
    if ({o_a[B_FI2], o_a[B_RW]} !== 2'b01) begin
      errors++;
      $display("FAIL redirect_single: got %b want 01", {o_a[B_FI2], o_a[B_RW]});
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_nofwd();
    reg_wen_wb = 1; rd_idx_wb = 5'd3; rs1_idx_id = 5'd3; rs1_used_id = 1; rs1_idx_ex = 5'd3;
    #1;
    checks++;
    if (o_c[B_LS] !== 1'b1) begin errors++; $display("FAIL nofwd_stall: got %b want 1", o_c[B_LS]); end
    checks++;
    if (o_c[6:3] !== 4'd0) begin errors++; $display("FAIL nofwd_sel: got %b want 0000", o_c[6:3]); end
    checks++;
    if (o_a[B_LS] !== 1'b0) begin errors++; $display("FAIL fwd_no_stall_wb: got %b want 0", o_a[B_LS]); end
    advance();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    jump_en_ex = 1;
    advance();
    jump_en_ex = 0;
    advance();
    rst = 1;
    #1;
    checks++;
    if (o_a !== 13'd0) begin errors++; $display("FAIL reset_mid_wait: got %b want 0", o_a); end
    advance();
    rst = 0;
    #1;
    checks++;
    if (o_a !== 13'd0) begin errors++; $display("FAIL reset_wait_release: got %b want 0", o_a); end
    advance();
    md_op_ex = 1;
    advance();
    advance();
    rst = 1;
    #1;
    checks++;
    if (o_a !== 13'd0) begin errors++; $display("FAIL reset_mid_count: got %b want 0", o_a); end
    advance();
    rst = 0;
    #1;
    checks++;
    if (o_a[B_MB] !== 1'b1) begin errors++; $display("FAIL reset_count_restart: got %b want 1", o_a[B_MB]); end
    md_op_ex = 0;
    #1;
    checks++;
    if (o_a !== 13'd0) begin errors++; $display("FAIL reset_count_release: got %b want 0", o_a); end
    advance();
    clear_inputs();
  endtask

  task automatic test_random();
    logic [12:0] exp_v;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      rs1_idx_id = 5'($urandom_range(0, 3)); rs2_idx_id = 5'($urandom_range(0, 3));
      rs1_idx_ex = 5'($urandom_range(0, 3)); rs2_idx_ex = 5'($urandom_range(0, 3));
      rd_idx_ex = 5'($urandom_range(0, 3)); rd_idx_mem = 5'($urandom_range(0, 3));
      rd_idx_wb = 5'($urandom_range(0, 3));
      rs1_used_id = 1'($urandom); rs2_used_id = 1'($urandom);
      reg_wen_ex = 1'($urandom); reg_wen_mem = 1'($urandom); reg_wen_wb = 1'($urandom);
      is_load_ex = 1'($urandom);
      md_op_ex = ($urandom_range(0, 3) != 0);
      jump_en_ex = ($urandom_range(0, 9) == 0);
      imem_rvalid = ($urandom_range(0, 2) == 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        exp_v = ref_out(k);
        checks++;
        if (pick(k) !== exp_v) begin
          errors++;
          $display("FAIL random n%0d dut%0d: got %b want %b", n, k, pick(k), exp_v);
        end
      end
      advance();
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      wait_m[k] = 0;
      streak_m[k] = 0;
    end
    @(negedge clk);
    test_reset();
    test_forward();
    test_load_use();
    test_muldiv();
    test_redirect();
    test_nofwd();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
